// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the execute stage: ALU controls, mul/div ops and the mul/div FSM states.
package execute_muldiv_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_uses_hilo(input logic [2:0] op);
    return md_is_arith(op) || (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // Magnitude of a value that is two's complement only when is_signed is set.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/execute_muldiv_muldiv_unit.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle, sign fix-up at the end.
module muldiv_unit
  import execute_muldiv_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [32:0]      acc;
  logic [31:0]      shreg;
  logic [31:0]      dvsr;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  logic             op_signed;
  logic             op_div;
  logic [32:0]      mul_sum;
  logic [32:0]      div_shift;
  logic [33:0]      div_trial;
  logic [32:0]      acc_nx;
  logic [31:0]      sh_nx;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix;
  logic [31:0]      rem_fix;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);

  // One iteration: mul shifts {acc,shreg} right after a conditional add; div shifts left and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, acc[31:0]} + (shreg[0] ? {1'b0, dvsr} : 33'd0);
    div_shift = {acc[31:0], shreg[31]};
    div_trial = {1'b0, div_shift} - {2'b00, dvsr};
    acc_nx    = {1'b0, mul_sum[32:1]};
    sh_nx     = {mul_sum[0], shreg[31:1]};
    if (is_div) begin
      if (!div_trial[33]) begin
        acc_nx = div_trial[32:0];
        sh_nx  = {shreg[30:0], 1'b1};
      end else begin
        acc_nx = div_shift;
        sh_nx  = {shreg[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_fix = neg_res ? (64'd0 - {acc[31:0], shreg}) : {acc[31:0], shreg};
    quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? (32'd0 - shreg) : shreg);
    rem_fix  = neg_rem ? (32'd0 - acc[31:0]) : acc[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      shreg    <= '0;
      dvsr     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state    <= MD_RUN;
            cnt      <= '0;
            acc      <= '0;
            shreg    <= magnitude(a, op_signed);
            dvsr     <= magnitude(b, op_signed);
            is_div   <= op_div;
            neg_res  <= op_signed && (a[31] ^ b[31]);
            neg_rem  <= op_signed && op_div && a[31];
            div_zero <= (b == 32'd0);
          end
        end
        MD_RUN: begin
          acc   <= acc_nx;
          shreg <= sh_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= MD_FIX;
        end
        MD_FIX: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[63:32];
            lo_r <= prod_fix[31:0];
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: ID/EX register, single-cycle ALU, HI/LO readout and stall generation around the mul/div unit.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] SrcA_ID,
  input  logic [31:0] SrcB_ID,
  input  logic [31:0] WrDat_ID,
  input  logic [4:0]  Shamt_ID,
  input  logic [3:0]  AluCtl_ID,
  input  logic [2:0]  MdOp_ID,
  input  logic        RegWrite_ID,
  input  logic        MemToReg_ID,
  input  logic        MemWrite_ID,
  input  logic        LoadB_ID,
  input  logic        StoreB_ID,
  input  logic        InstrVal_ID,
  input  logic [4:0]  WriteReg_ID,
  output logic [31:0] Result_EX,
  output logic [31:0] WrDat_EX,
  output logic        RegWrite_EX,
  output logic        MemToReg_EX,
  output logic        MemWrite_EX,
  output logic        LoadB_EX,
  output logic        StoreB_EX,
  output logic        InstrVal_EX,
  output logic [4:0]  WriteReg_EX,
  output logic        MulDivStall_EX,
  output logic        MdBusy_EX
);

  logic signed [31:0] src_a_p1;
  logic signed [31:0] src_b_p1;
  logic [31:0]        wr_dat_p1;
  logic [4:0]         shamt_p1;
  logic [3:0]         alu_ctl_p1;
  logic [2:0]         md_op_p1;
  logic               reg_write_p1;
  logic               mem_to_reg_p1;
  logic               mem_write_p1;
  logic               load_b_p1;
  logic               store_b_p1;
  logic               vld_p1;
  logic [4:0]         write_reg_p1;

  logic               md_busy;
  logic               md_stall;
  logic               md_start;
  logic [31:0]        md_hi;
  logic [31:0]        md_lo;
  logic [31:0]        alu_res;

  // Hold any HI/LO user in ID while an older mul/div is in EX or still iterating.
  assign md_stall = (md_busy || md_is_arith(md_op_p1)) && md_uses_hilo(MdOp_ID);
  assign md_start = !flush && !AnyStall && !md_stall && md_is_arith(MdOp_ID);

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_p1      <= '0;
      src_b_p1      <= '0;
      wr_dat_p1     <= '0;
      shamt_p1      <= '0;
      alu_ctl_p1    <= '0;
      md_op_p1      <= MD_NONE;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      load_b_p1     <= 1'b0;
      store_b_p1    <= 1'b0;
      vld_p1        <= 1'b0;
      write_reg_p1  <= '0;
    end else if (flush || (!AnyStall && md_stall)) begin
      md_op_p1      <= MD_NONE;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      load_b_p1     <= 1'b0;
      store_b_p1    <= 1'b0;
      vld_p1        <= 1'b0;
    end else if (!AnyStall) begin
      src_a_p1      <= SrcA_ID;
      src_b_p1      <= SrcB_ID;
      wr_dat_p1     <= WrDat_ID;
      shamt_p1      <= Shamt_ID;
      alu_ctl_p1    <= AluCtl_ID;
      md_op_p1      <= MdOp_ID;
      reg_write_p1  <= RegWrite_ID;
      mem_to_reg_p1 <= MemToReg_ID;
      mem_write_p1  <= MemWrite_ID;
      load_b_p1     <= LoadB_ID;
      store_b_p1    <= StoreB_ID;
      vld_p1        <= InstrVal_ID;
      write_reg_p1  <= WriteReg_ID;
    end
  end

  // ---- EX: combinational ALU ----
  always_comb begin
    case (alu_ctl_p1)
      ALU_AND:  alu_res = src_a_p1 & src_b_p1;
      ALU_OR:   alu_res = src_a_p1 | src_b_p1;
      ALU_ADD:  alu_res = src_a_p1 + src_b_p1;
      ALU_SUB:  alu_res = src_a_p1 - src_b_p1;
      ALU_SLT:  alu_res = {31'd0, (src_a_p1 < src_b_p1)};
      ALU_SLTU: alu_res = {31'd0, ($unsigned(src_a_p1) < $unsigned(src_b_p1))};
      ALU_NOR:  alu_res = ~(src_a_p1 | src_b_p1);
      ALU_SLL:  alu_res = src_b_p1 << shamt_p1;
      ALU_SRL:  alu_res = $unsigned(src_b_p1) >> shamt_p1;
      ALU_SRA:  alu_res = src_b_p1 >>> shamt_p1;
      default:  alu_res = 32'd0;
    endcase
  end

  muldiv_unit #(
    .MD_ITERS(MD_ITERS)
  ) u_muldiv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(md_start),
    .op   (MdOp_ID),
    .a    (SrcA_ID),
    .b    (SrcB_ID),
    .busy (md_busy),
    .hi   (md_hi),
    .lo   (md_lo)
  );

  assign Result_EX      = (md_op_p1 == MD_MFHI) ? md_hi :
                          (md_op_p1 == MD_MFLO) ? md_lo : alu_res;
  assign WrDat_EX       = wr_dat_p1;
  assign RegWrite_EX    = reg_write_p1;
  assign MemToReg_EX    = mem_to_reg_p1;
  assign MemWrite_EX    = mem_write_p1;
  assign LoadB_EX       = load_b_p1;
  assign StoreB_EX      = store_b_p1;
  assign InstrVal_EX    = vld_p1;
  assign WriteReg_EX    = write_reg_p1;
  assign MulDivStall_EX = md_stall;
  assign MdBusy_EX      = md_busy;

endmodule
